// File: rtl/shift_pkg.sv
// Shared types and constants for the shift issue/retire stage.
// Consumers: shift_fifo2, shift_issue_stage.
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int TAG_W   = 5;
    localparam int DEPTH   = 2;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0]  a;
        logic [SHAMT_W-1:0] shamt;
        logic               op;
        logic [TAG_W-1:0]   tag;
    } shift_entry_t;

    function automatic logic [DATA_W-1:0] bitrev32(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = x[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_fifo2.sv
// Two-entry FIFO of shift ops with occupancy count and wrap-around pointers.
// The head reads as all-zero when empty so the shifter sees a quiet input.
module shift_fifo2
    import shift_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  shift_entry_t wr_entry,
    output shift_entry_t head_entry,
    output logic [1:0]   count
);

    shift_entry_t mem_q [DEPTH];
    shift_entry_t mem_d [DEPTH];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok;
    logic         pop_ok;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_ok = push && (count_q != 2'd2);
    assign pop_ok  = pop  && (count_q != 2'd0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observed after it is written.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign head_entry = (count_q == 2'd0) ? '0 : mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/shift_issue_stage.sv
// Issue/retire stage wrapped around an external 32-bit left barrel shifter.
// Optional SHIFT_SRA_EN macro enables arithmetic right shift via bit reversal.
module shift_issue_stage
    import shift_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic [DATA_W-1:0]  shf_a,
    output logic [SHAMT_W-1:0] shf_amt,
    input  logic [DATA_W-1:0]  shf_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic [15:0]        op_count
);

`ifdef SHIFT_SRA_EN
    localparam logic SRA_EN = 1'b1;
`else
    localparam logic SRA_EN = 1'b0;
`endif

    shift_entry_t       push_entry;
    shift_entry_t       head;
    logic [1:0]         count;
    logic               push;
    logic               load;
    logic               drain;
    logic               is_sra;
    logic [DATA_W-1:0]  sign_fill;
    logic [DATA_W-1:0]  result;

    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q,  out_data_d;
    logic [TAG_W-1:0]   out_tag_q,   out_tag_d;
    logic [15:0]        op_count_q,  op_count_d;

    // Ready depends only on registered occupancy, held low while in reset.
    assign in_ready = reset && (count != 2'd2);
    assign push     = in_valid && in_ready;
    assign load     = (count != 2'd0) && (!out_valid_q || out_ready);
    assign drain    = out_valid_q && out_ready;

    // With SRA disabled the op bit is forced to SLL, so the reversal path folds away.
    always_comb begin
        push_entry.a     = in_a;
        push_entry.shamt = in_shamt;
        push_entry.op    = (SRA_EN && (in_op == OP_SRA)) ? OP_SRA : OP_SLL;
        push_entry.tag   = in_tag;
    end

    shift_fifo2 u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .pop        (load),
        .wr_entry   (push_entry),
        .head_entry (head),
        .count      (count)
    );

    // SRA: reverse, left-shift, reverse back gives a logical right shift; then sign-fill.
    always_comb begin
        is_sra    = (head.op == OP_SRA);
        shf_a     = is_sra ? bitrev32(head.a) : head.a;
        shf_amt   = head.shamt;
        sign_fill = (is_sra && head.a[DATA_W-1]) ? ~({DATA_W{1'b1}} >> head.shamt) : '0;
        result    = is_sra ? (bitrev32(shf_result) | sign_fill) : shf_result;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        op_count_d  = op_count_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = result;
            out_tag_d   = head.tag;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
        if (drain) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            op_count_q  <= 16'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            op_count_q  <= op_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage with a queue scoreboard.
// The external shifter is modelled as a plain left shift.
module tb_shift_issue_stage;
    import shift_pkg::*;

`ifdef SHIFT_SRA_EN
    localparam bit SRA_ON = 1'b1;
`else
    localparam bit SRA_ON = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DATA_W-1:0]  in_a = '0;
    logic [SHAMT_W-1:0] in_shamt = '0;
    logic               in_op = 1'b0;
    logic [TAG_W-1:0]   in_tag = '0;
    logic [DATA_W-1:0]  shf_a;
    logic [SHAMT_W-1:0] shf_amt;
    logic [DATA_W-1:0]  shf_result;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DATA_W-1:0]  out_data;
    logic [TAG_W-1:0]   out_tag;
    logic [15:0]        op_count;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_ops = 0;

    always #5 clock = ~clock;

    assign shf_result = shf_a << shf_amt;

    shift_issue_stage dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_shamt   (in_shamt),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .shf_a      (shf_a),
        .shf_amt    (shf_amt),
        .shf_result (shf_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .op_count   (op_count)
    );

    function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] a,
                                                input logic [SHAMT_W-1:0] s,
                                                input logic op);
        logic signed [DATA_W-1:0] sa;
        sa = a;
        if (SRA_ON && op) return sa >>> s;
        return a << s;
    endfunction

    // Scoreboard: record accepted ops, compare on each writeback handshake.
    always @(negedge clock) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got data=%h tag=%0d, required no output", out_data, out_tag);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_data !== mon_e.data || out_tag !== mon_e.tag) begin
                        n_err++;
                        $display("FAIL sb_order: got data=%h tag=%0d, required data=%h tag=%0d",
                                 out_data, out_tag, mon_e.data, mon_e.tag);
                    end
                end
            end
            if (in_valid && in_ready) begin
                mon_e.data = model(in_a, in_shamt, in_op);
                mon_e.tag  = in_tag;
                exp_q.push_back(mon_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] a, input logic [SHAMT_W-1:0] s,
                         input logic op, input logic [TAG_W-1:0] tag);
        in_valid = v;
        in_a     = a;
        in_shamt = s;
        in_op    = op;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 5'd3, OP_SLL, 5'd9);
        out_ready = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0 || op_count !== 16'd0) begin
            n_err++; $display("FAIL rst_out: got valid=%b count=%0d, required 0/0", out_valid, op_count);
        end
        n_cmp++;
        if (out_data !== '0 || out_tag !== '0) begin
            n_err++; $display("FAIL rst_data: got data=%h tag=%0d, required 0/0", out_data, out_tag);
        end
        drive(1'b0, '0, '0, OP_SLL, '0);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b, required 1", in_ready); end
        n_cmp++;
        if (shf_a !== '0 || shf_amt !== '0) begin
            n_err++; $display("FAIL empty_shf: got a=%h amt=%0d, required 0/0", shf_a, shf_amt);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_no_push: got valid=%b, required 0", out_valid); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0001, 5'd31, OP_SLL, 5'd7);
        tick();
        drive(1'b0, '0, '0, OP_SLL, '0);
        n_cmp++;
        if (out_valid !== 1'b0 || shf_a !== 32'h1 || shf_amt !== 5'd31) begin
            n_err++; $display("FAIL single_head: got valid=%b a=%h amt=%0d, required 0/1/31", out_valid, shf_a, shf_amt);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h8000_0000 || out_tag !== 5'd7) begin
            n_err++; $display("FAIL single_out: got valid=%b data=%h tag=%0d, required 1/80000000/7",
                              out_valid, out_data, out_tag);
        end
        tick();
        exp_ops += 1;
        n_cmp++;
        if (op_count !== 16'(exp_ops) || out_valid !== 1'b0) begin
            n_err++; $display("FAIL single_count: got count=%0d valid=%b, required %0d/0", op_count, out_valid, exp_ops);
        end
    endtask

    task automatic test_back_to_back();
        logic [SHAMT_W-1:0] sh [4];
        logic [DATA_W-1:0]  ex [4];
        sh = '{5'd0, 5'd1, 5'd4, 5'd16};
        ex = '{32'h1, 32'h2, 32'h10, 32'h1_0000};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1, sh[i], OP_SLL, 5'(i + 1));
            n_cmp++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b, required 1", i, in_ready); end
            tick();
            if (i > 0) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== ex[i-1]) begin
                    n_err++; $display("FAIL b2b_data[%0d]: got valid=%b data=%h, required 1/%h", i - 1, out_valid, out_data, ex[i-1]);
                end
            end
        end
        drive(1'b0, '0, '0, OP_SLL, '0);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== ex[3]) begin
            n_err++; $display("FAIL b2b_data[3]: got valid=%b data=%h, required 1/%h", out_valid, out_data, ex[3]);
        end
        tick();
        exp_ops += 4;
        n_cmp++;
        if (out_valid !== 1'b0 || op_count !== 16'(exp_ops)) begin
            n_err++; $display("FAIL b2b_drain: got valid=%b count=%0d, required 0/%0d", out_valid, op_count, exp_ops);
        end
    endtask

    task automatic test_backpressure();
        int  accepted = 0;
        bit  done = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (accepted < 4) drive(1'b1, 32'h3, 5'(accepted + 1), OP_SLL, 5'(10 + accepted));
            else              drive(1'b0, '0, '0, OP_SLL, '0);
            if (in_valid && in_ready) accepted++;
            tick();
        end
        n_cmp++;
        if (accepted != 3 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_full: got accepted=%0d in_ready=%b, required 3/0", accepted, in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h6 || out_tag !== 5'd10) begin
            n_err++; $display("FAIL bp_hold: got valid=%b data=%h tag=%0d, required 1/6/10", out_valid, out_data, out_tag);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            if (accepted < 4) drive(1'b1, 32'h3, 5'(accepted + 1), OP_SLL, 5'(10 + accepted));
            else              drive(1'b0, '0, '0, OP_SLL, '0);
            if (in_valid && in_ready) accepted++;
            tick();
            if (accepted == 4 && !in_valid && out_valid === 1'b0 && exp_q.size() == 0) done = 1'b1;
            if (accepted == 4) drive(1'b0, '0, '0, OP_SLL, '0);
        end
        exp_ops += 4;
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL bp_drain_timeout: got pending=%0d, required 0", exp_q.size()); end
        n_cmp++;
        if (op_count !== 16'(exp_ops)) begin
            n_err++; $display("FAIL bp_count: got %0d, required %0d", op_count, exp_ops);
        end
    endtask

    task automatic test_sra();
        logic [DATA_W-1:0] aa [4];
        logic [SHAMT_W-1:0] ss [4];
        logic [DATA_W-1:0] ex [4];
        aa = '{32'h8000_0000, 32'h4000_0000, 32'h0000_00F1, 32'h8000_0001};
        ss = '{5'd4, 5'd4, 5'd4, 5'd0};
        if (SRA_ON) ex = '{32'hF800_0000, 32'h0400_0000, 32'h0000_000F, 32'h8000_0001};
        else        ex = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0F10, 32'h8000_0001};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, aa[i], ss[i], OP_SRA, 5'(20 + i));
            else       drive(1'b0, '0, '0, OP_SLL, '0);
            tick();
            if (i > 0) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== ex[i-1]) begin
                    n_err++; $display("FAIL sra[%0d]: got valid=%b data=%h, required 1/%h", i - 1, out_valid, out_data, ex[i-1]);
                end
            end
        end
        tick();
        exp_ops += 4;
        n_cmp++;
        if (op_count !== 16'(exp_ops)) begin
            n_err++; $display("FAIL sra_count: got %0d, required %0d", op_count, exp_ops);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 8 && in_ready; c++) begin
            drive(1'b1, 32'h5, 5'(c), OP_SLL, 5'(c));
            tick();
        end
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL mr_fill: got in_ready=%b valid=%b, required 0/1", in_ready, out_valid);
        end
        reset = 1'b0;
        exp_q.delete();
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || op_count !== 16'd0 || out_data !== '0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL mr_clear: got valid=%b count=%0d data=%h ready=%b, required 0/0/0/0",
                              out_valid, op_count, out_data, in_ready);
        end
        drive(1'b0, '0, '0, OP_SLL, '0);
        reset = 1'b1;
        out_ready = 1'b1;
        exp_ops = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_stale[%0d]: got valid=%b, required 0", c, out_valid); end
        end
        drive(1'b1, 32'h5, 5'd2, OP_SLL, 5'd3);
        tick();
        drive(1'b0, '0, '0, OP_SLL, '0);
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h14 || out_tag !== 5'd3) begin
            n_err++; $display("FAIL mr_fresh: got valid=%b data=%h tag=%0d, required 1/14/3", out_valid, out_data, out_tag);
        end
        tick();
        exp_ops += 1;
        n_cmp++;
        if (op_count !== 16'(exp_ops)) begin
            n_err++; $display("FAIL mr_count: got %0d, required %0d", op_count, exp_ops);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_sra();
        test_mid_reset();
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
